// File: rtl/disp_hm_if.sv
// Counter-side digits in, board-side display pins out for the HH:MM display driver.
interface disp_hm_if;
  logic       enable1hz;
  logic [1:0] bcd_h_msd;
  logic [3:0] bcd_h_lsd;
  logic [2:0] bcd_m_msd;
  logic [3:0] bcd_m_lsd;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output enable1hz, bcd_h_msd, bcd_h_lsd, bcd_m_msd, bcd_m_lsd,
    input  seg, an, dp
  );

  modport slave (
    input  enable1hz, bcd_h_msd, bcd_h_lsd, bcd_m_msd, bcd_m_lsd,
    output seg, an, dp
  );
endinterface

// File: rtl/disp_hm.sv
// 4-digit multiplexed 7-segment driver for HH:MM with per-frame snapshot and blinking colon.
// Optional DISP_LZ_BLANK_EN: blank the hour tens digit when it is zero.
module disp_hm #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic      clock,
  input  logic      reset,
  disp_hm_if.slave  d
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic             col_q, col_d;
  // Minute units is shown in the capture cycle itself, so only three digits need holding.
  logic [2:0]       snap_m_msd_q, snap_m_msd_d;
  logic [3:0]       snap_h_lsd_q, snap_h_lsd_d;
  logic [1:0]       snap_h_msd_q, snap_h_msd_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             tick;
  logic [3:0]       dig;
  logic [3:0]       lim;

  function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic [3:0] max_v);
    logic [6:0] s;
    s = SEG_DASH;
    if (v <= max_v) begin
      case (v)
        4'd0:    s = 7'b1000000;
        4'd1:    s = 7'b1111001;
        4'd2:    s = 7'b0100100;
        4'd3:    s = 7'b0110000;
        4'd4:    s = 7'b0011001;
        4'd5:    s = 7'b0010010;
        4'd6:    s = 7'b0000010;
        4'd7:    s = 7'b1111000;
        4'd8:    s = 7'b0000000;
        4'd9:    s = 7'b0010000;
        default: s = SEG_DASH;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    pre_d        = pre_q;
    idx_d        = idx_q;
    col_d        = col_q ^ d.enable1hz;
    snap_m_msd_d = snap_m_msd_q;
    snap_h_lsd_d = snap_h_lsd_q;
    snap_h_msd_d = snap_h_msd_q;
    seg_d        = seg_q;
    an_d         = an_q;
    dp_d         = dp_q;
    dig          = 4'd0;
    lim          = 4'd9;

    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);

    if (tick) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_d)
        2'd0: begin
          snap_m_msd_d = d.bcd_m_msd;
          snap_h_lsd_d = d.bcd_h_lsd;
          snap_h_msd_d = d.bcd_h_msd;
          dig          = d.bcd_m_lsd;
          lim          = 4'd9;
        end
        2'd1: begin
          dig = {1'b0, snap_m_msd_q};
          lim = 4'd5;
        end
        2'd2: begin
          dig = snap_h_lsd_q;
          lim = 4'd9;
        end
        2'd3: begin
          dig = {2'b00, snap_h_msd_q};
          lim = 4'd2;
        end
      endcase
      seg_d = seg_decode(dig, lim);
`ifdef DISP_LZ_BLANK_EN
      if ((idx_d == 2'd3) && (snap_h_msd_q == 2'd0)) seg_d = SEG_OFF;
`endif
      an_d = ~(4'b0001 << idx_d);
      // Colon uses the flag as it stood before any toggle landing in this same cycle.
      dp_d = (idx_d == 2'd2) ? ~col_q : 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= 2'd3;
      col_q        <= 1'b0;
      snap_m_msd_q <= '0;
      snap_h_lsd_q <= '0;
      snap_h_msd_q <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      snap_m_msd_q <= snap_m_msd_d;
      snap_h_lsd_q <= snap_h_lsd_d;
      snap_h_msd_q <= snap_h_msd_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign d.seg = seg_q;
  assign d.an  = an_q;
  assign d.dp  = dp_q;

endmodule

// File: tb/tb_disp_hm.sv
// Self-checking bench for disp_hm: time-based reference model plus directed literal checks.
module tb_disp_hm;
  localparam int unsigned SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  disp_hm_if dif();

  disp_hm #(.SCAN_DIV(SD)) dut (
    .clock (clk),
    .reset (rst),
    .d     (dif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: position in the scan follows from cycles elapsed since reset.
  int         t       = 0;
  bit         m_valid = 1'b0;
  bit         m_col   = 1'b0;
  int         snap [4];
  logic [6:0] e_seg   = 7'h7f;
  logic [3:0] e_an    = 4'hf;
  logic       e_dp    = 1'b1;

  function automatic logic [6:0] exp_digit(int k, int v);
    int lim = (k == 1) ? 5 : ((k == 3) ? 2 : 9);
    if (v > lim) return 7'b0111111;
`ifdef DISP_LZ_BLANK_EN
    if (k == 3 && v == 0) return 7'b1111111;
`endif
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_col = 1'b0; m_valid = 1'b1;
      e_seg = 7'h7f; e_an = 4'hf; e_dp = 1'b1;
    end else if (m_valid) begin
      t++;
      if (t % SD == 0) begin
        int k;
        k = (t / SD - 1) % 4;
        if (k == 0) begin
          snap[0] = int'(dif.bcd_m_lsd);
          snap[1] = int'(dif.bcd_m_msd);
          snap[2] = int'(dif.bcd_h_lsd);
          snap[3] = int'(dif.bcd_h_msd);
        end
        e_an  = ~(4'b0001 << k);
        e_seg = exp_digit(k, snap[k]);
        e_dp  = (k == 2) ? !m_col : 1'b1;
      end
      if (dif.enable1hz) m_col = !m_col;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_chk++;
      if ({dif.seg, dif.an, dif.dp} !== {e_seg, e_an, e_dp}) begin
        n_fail++;
        $display("FAIL model t=%0d seg/an/dp act=%b/%b/%b exp=%b/%b/%b",
                 t, dif.seg, dif.an, dif.dp, e_seg, e_an, e_dp);
      end
      if (e_an != 4'hf) begin
        n_chk++;
        if ($countones(~dif.an) != 1) begin
          n_fail++;
          $display("FAIL onehot t=%0d an act=%b exp=one low bit", t, dif.an);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(logic [1:0] h1, logic [3:0] h0, logic [2:0] m1, logic [3:0] m0);
    dif.bcd_h_msd = h1; dif.bcd_h_lsd = h0; dif.bcd_m_msd = m1; dif.bcd_m_lsd = m0;
  endtask

  task automatic chk_seg(string nm, logic [6:0] exp);
    n_chk++;
    if (dif.seg !== exp) begin
      n_fail++;
      $display("FAIL %s seg act=%b exp=%b", nm, dif.seg, exp);
    end
  endtask

  task automatic chk_an(string nm, logic [3:0] exp);
    n_chk++;
    if (dif.an !== exp) begin
      n_fail++;
      $display("FAIL %s an act=%b exp=%b", nm, dif.an, exp);
    end
  endtask

  task automatic chk_dp(string nm, logic exp);
    n_chk++;
    if (dif.dp !== exp) begin
      n_fail++;
      $display("FAIL %s dp act=%b exp=%b", nm, dif.dp, exp);
    end
  endtask

  task automatic pulse_1hz();
    dif.enable1hz = 1'b1;
    step(1);
    dif.enable1hz = 1'b0;
  endtask

  initial begin
    dif.enable1hz = 1'b0;
    set_in(2'd1, 4'd2, 3'd3, 4'd4);
    step(2);
    rst = 1'b0;
    chk_an("rst_an", 4'b1111); chk_seg("rst_seg", 7'b1111111); chk_dp("rst_dp", 1'b1);
    step(3);  chk_an("dark_t3", 4'b1111);
    step(1);  chk_an("d0_an", 4'b1110); chk_seg("d0_seg4", 7'b0011001);
    step(4);  chk_an("d1_an", 4'b1101); chk_seg("d1_seg3", 7'b0110000);
    set_in(2'd1, 4'd2, 3'd3, 4'd5);
    step(4);  chk_an("d2_an", 4'b1011); chk_seg("d2_seg2", 7'b0100100); chk_dp("d2_dp_off", 1'b1);
    step(4);  chk_an("d3_an", 4'b0111); chk_seg("d3_seg1", 7'b1111001);
    step(4);  chk_an("f2_an", 4'b1110); chk_seg("f2_seg5", 7'b0010010);
    pulse_1hz();
    step(3);  chk_dp("col_idx1", 1'b1);
    step(4);  chk_an("col_an2", 4'b1011); chk_dp("col_on", 1'b0);
    step(4);  chk_dp("col_idx3", 1'b1);
    pulse_1hz();
    step(11); chk_an("col2_an2", 4'b1011); chk_dp("col_off", 1'b1);
    step(15);
    pulse_1hz();
    chk_an("coinc_an2", 4'b1011); chk_dp("coinc_old", 1'b1);
    step(16); chk_an("coinc_next", 4'b1011); chk_dp("coinc_new", 1'b0);
    set_in(2'd3, 4'd2, 3'd3, 4'd12);
    step(8);  chk_an("inv_an0", 4'b1110); chk_seg("inv_mlsd", 7'b0111111);
    step(4);  chk_seg("inv_mmsd_ok", 7'b0110000);
    step(4);  chk_seg("inv_hlsd_ok", 7'b0100100);
    step(4);  chk_an("inv_an3", 4'b0111); chk_seg("inv_hmsd", 7'b0111111);
    set_in(2'd0, 4'd9, 3'd0, 4'd5);
    step(4);  chk_seg("lz_d0", 7'b0010010);
    step(4);  chk_seg("lz_d1", 7'b1000000);
    step(4);  chk_seg("lz_d2", 7'b0010000);
    step(4);  chk_an("lz_an3", 4'b0111);
`ifdef DISP_LZ_BLANK_EN
    chk_seg("lz_blank", 7'b1111111);
`else
    chk_seg("lz_zero", 7'b1000000);
`endif
    step(12); chk_an("pre_rst_an2", 4'b1011);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_an("mid_rst_an", 4'b1111); chk_dp("mid_rst_dp", 1'b1); chk_seg("mid_rst_seg", 7'b1111111);
    step(3);  chk_an("mid_rst_dark", 4'b1111);
    step(1);  chk_an("restart_an", 4'b1110); chk_seg("restart_seg", 7'b0010010);
    step(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
